// File: rtl/control_botones.sv
// Push-button front end for the BCD counter: synchronises and debounces RUN/CLR and
// turns accepted presses into a run-enable level plus clear and long-press pulses.

package control_botones_pkg;
  // Bit 1 of the encoding is the debounced "pressed" level (HELD or DB_REL).
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DB_PRESS = 2'b01,
    HELD     = 2'b10,
    DB_REL   = 2'b11
  } db_state_t;
endpackage

// One button: 2-FF synchroniser, debounce FSM and a single-cycle press event.
module boton_db
  import control_botones_pkg::*;
#(
  parameter int DB_LIMIT = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      btn_n,
  output logic      press_evt,
  output db_state_t state
);

  localparam int CW = (DB_LIMIT > 1) ? $clog2(DB_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_LIMIT - 1);

  logic          sync1, sync2;
  logic          pressed_s;
  logic [CW-1:0] cnt, cnt_nx;
  db_state_t     state_nx;

  // Synchroniser idles at 1 so a reset never looks like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  assign pressed_s = ~sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    press_evt = 1'b0;
    case (state)
      IDLE: begin
        if (pressed_s) begin
          state_nx = DB_PRESS;
          cnt_nx   = '0;
        end
      end
      DB_PRESS: begin
        if (!pressed_s) begin
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nx  = HELD;
          press_evt = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!pressed_s) begin
          state_nx = DB_REL;
          cnt_nx   = '0;
        end
      end
      DB_REL: begin
        if (pressed_s) begin
          state_nx = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// Handshake-free control: every output is a flop; press events are single-cycle
// strobes from the debounce FSMs, consumed on the same edge that enters HELD.
module control_botones
  import control_botones_pkg::*;
#(
  parameter int FREQ_CLK    = 50000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run_n,
  input  logic btn_clr_n,
  output logic run_en,
  output logic clr_pulse,
  output logic clr_long,
  output logic run_db,
  output logic clr_db
);

  localparam int DB_LIMIT   = (FREQ_CLK / 1000) * DEBOUNCE_MS;
  localparam int LONG_LIMIT = (FREQ_CLK / 1000) * LONG_MS;
  // One extra count of headroom lets the hold counter park past the fire point.
  localparam int HW = $clog2(LONG_LIMIT + 1);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_LIMIT - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_LIMIT);

  db_state_t     run_state, clr_state;
  logic          run_evt, clr_evt, long_evt;
  logic [HW-1:0] hold_cnt, hold_cnt_nx;
  logic          run_en_nx;

  boton_db #(.DB_LIMIT(DB_LIMIT)) u_run (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_run_n),
    .press_evt (run_evt),
    .state     (run_state)
  );

  boton_db #(.DB_LIMIT(DB_LIMIT)) u_clr (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_clr_n),
    .press_evt (clr_evt),
    .state     (clr_state)
  );

  assign run_db = run_state[1];
  assign clr_db = clr_state[1];

  // A release bounce (DB_REL) freezes the hold count instead of restarting it.
  always_comb begin
    hold_cnt_nx = hold_cnt;
    case (clr_state)
      HELD:    if (hold_cnt != HOLD_SAT) hold_cnt_nx = hold_cnt + 1'b1;
      DB_REL:  hold_cnt_nx = hold_cnt;
      default: hold_cnt_nx = '0;
    endcase
  end

  assign long_evt = (clr_state == HELD) && (hold_cnt == HOLD_FIRE);

  // CLR and long-press both win over a same-cycle RUN toggle.
  always_comb begin
    run_en_nx = run_en;
    if (clr_evt || long_evt) run_en_nx = 1'b0;
    else if (run_evt)        run_en_nx = ~run_en;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt  <= '0;
      run_en    <= 1'b0;
      clr_pulse <= 1'b0;
      clr_long  <= 1'b0;
    end else begin
      hold_cnt  <= hold_cnt_nx;
      run_en    <= run_en_nx;
      clr_pulse <= clr_evt;
      clr_long  <= long_evt;
    end
  end

endmodule

// File: tb/tb_control_botones.sv
// Directed bench for control_botones with DB_LIMIT=4 and LONG_LIMIT=20.
module tb_control_botones;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_run_n = 1'b1;
  logic btn_clr_n = 1'b1;
  logic run_en, clr_pulse, clr_long, run_db, clr_db;

  int n_cmp = 0;
  int n_err = 0;

  // Event counters sampled on the falling edge; tasks use differences.
  int   tog_cnt = 0;
  int   pulse_cnt = 0;
  int   long_cnt = 0;
  logic run_prev = 1'b0;

  control_botones #(
    .FREQ_CLK    (1000),
    .DEBOUNCE_MS (4),
    .LONG_MS     (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_run_n (btn_run_n),
    .btn_clr_n (btn_clr_n),
    .run_en    (run_en),
    .clr_pulse (clr_pulse),
    .clr_long  (clr_long),
    .run_db    (run_db),
    .clr_db    (clr_db)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (run_en !== run_prev) tog_cnt++;
    run_prev = run_en;
    if (clr_pulse === 1'b1) pulse_cnt++;
    if (clr_long === 1'b1) long_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    btn_run_n = 1'b1;
    btn_clr_n = 1'b1;
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    int t0;
    step(1);
    rst = 1'b0;
    btn_run_n = 1'b0;
    btn_clr_n = 1'b1;
    step(3);
    n_cmp++;
    if ({run_en, clr_pulse, clr_long, run_db, clr_db} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 00000", {run_en, clr_pulse, clr_long, run_db, clr_db});
    end
    t0 = tog_cnt;
    rst = 1'b1;
    step(6);
    n_cmp++;
    if (run_en !== 1'b0) begin n_err++; $display("FAIL reset_early: run_en got %b want 0", run_en); end
    step(1);
    n_cmp++;
    if (run_en !== 1'b1 || run_db !== 1'b1) begin
      n_err++; $display("FAIL reset_redetect: run_en/run_db got %b%b want 11", run_en, run_db);
    end
    step(10);
    n_cmp++;
    if (tog_cnt - t0 !== 1) begin n_err++; $display("FAIL reset_one_event: toggles got %0d want 1", tog_cnt - t0); end
    btn_run_n = 1'b1;
    step(12);
    n_cmp++;
    if (run_db !== 1'b0) begin n_err++; $display("FAIL reset_release: run_db got %b want 0", run_db); end
  endtask

  task automatic test_clean_run();
    do_reset();
    btn_run_n = 1'b0;
    step(6);
    n_cmp++;
    if (run_en !== 1'b0) begin n_err++; $display("FAIL run_latency_early: run_en got %b want 0", run_en); end
    step(1);
    n_cmp++;
    if (run_en !== 1'b1 || run_db !== 1'b1) begin
      n_err++; $display("FAIL run_latency: run_en/run_db got %b%b want 11", run_en, run_db);
    end
    step(3);
    btn_run_n = 1'b1;
    step(12);
    n_cmp++;
    if (run_en !== 1'b1 || run_db !== 1'b0) begin
      n_err++; $display("FAIL run_after_release: run_en/run_db got %b%b want 10", run_en, run_db);
    end
    btn_run_n = 1'b0;
    step(10);
    btn_run_n = 1'b1;
    step(12);
    n_cmp++;
    if (run_en !== 1'b0) begin n_err++; $display("FAIL run_second_press: run_en got %b want 0", run_en); end
  endtask

  task automatic test_bounce();
    int t0;
    do_reset();
    t0 = tog_cnt;
    btn_run_n = 1'b0; step(2);
    btn_run_n = 1'b1; step(1);
    btn_run_n = 1'b0; step(10);
    btn_run_n = 1'b1; step(12);
    n_cmp++;
    if (tog_cnt - t0 !== 1 || run_en !== 1'b1) begin
      n_err++; $display("FAIL bounce_press: toggles %0d run_en %b want 1 1", tog_cnt - t0, run_en);
    end
    t0 = tog_cnt;
    btn_run_n = 1'b0; step(3);
    btn_run_n = 1'b1; step(15);
    n_cmp++;
    if (tog_cnt - t0 !== 0 || run_en !== 1'b1 || run_db !== 1'b0) begin
      n_err++; $display("FAIL glitch_reject: toggles %0d run_en %b run_db %b want 0 1 0", tog_cnt - t0, run_en, run_db);
    end
  endtask

  task automatic test_clr();
    int p0, l0;
    do_reset();
    btn_run_n = 1'b0; step(10);
    btn_run_n = 1'b1; step(12);
    n_cmp++;
    if (run_en !== 1'b1) begin n_err++; $display("FAIL clr_setup: run_en got %b want 1", run_en); end
    p0 = pulse_cnt;
    l0 = long_cnt;
    btn_clr_n = 1'b0;
    step(6);
    n_cmp++;
    if (clr_pulse !== 1'b0 || run_en !== 1'b1) begin
      n_err++; $display("FAIL clr_early: clr_pulse/run_en got %b%b want 01", clr_pulse, run_en);
    end
    step(1);
    n_cmp++;
    if (clr_pulse !== 1'b1 || run_en !== 1'b0 || clr_db !== 1'b1) begin
      n_err++; $display("FAIL clr_pulse: clr_pulse/run_en/clr_db got %b%b%b want 101", clr_pulse, run_en, clr_db);
    end
    step(1);
    n_cmp++;
    if (clr_pulse !== 1'b0) begin n_err++; $display("FAIL clr_one_cycle: clr_pulse got %b want 0", clr_pulse); end
    step(2);
    btn_clr_n = 1'b1; step(2);
    btn_clr_n = 1'b0; step(1);
    btn_clr_n = 1'b1; step(15);
    n_cmp++;
    if (pulse_cnt - p0 !== 1 || long_cnt - l0 !== 0 || clr_db !== 1'b0) begin
      n_err++; $display("FAIL clr_release_bounce: pulses %0d longs %0d clr_db %b want 1 0 0", pulse_cnt - p0, long_cnt - l0, clr_db);
    end
  endtask

  task automatic test_long();
    int p0, l0, t0;
    do_reset();
    p0 = pulse_cnt;
    l0 = long_cnt;
    t0 = tog_cnt;
    btn_clr_n = 1'b0;
    step(7);
    n_cmp++;
    if (clr_pulse !== 1'b1) begin n_err++; $display("FAIL long_clr_pulse: clr_pulse got %b want 1", clr_pulse); end
    step(1);
    btn_run_n = 1'b0;
    step(7);
    n_cmp++;
    if (run_en !== 1'b1) begin n_err++; $display("FAIL long_run_during_hold: run_en got %b want 1", run_en); end
    step(3);
    btn_run_n = 1'b1;
    step(8);
    n_cmp++;
    if (clr_long !== 1'b0 || run_en !== 1'b1) begin
      n_err++; $display("FAIL long_early: clr_long/run_en got %b%b want 01", clr_long, run_en);
    end
    step(1);
    n_cmp++;
    if (clr_long !== 1'b1 || run_en !== 1'b0) begin
      n_err++; $display("FAIL long_fire: clr_long/run_en got %b%b want 10", clr_long, run_en);
    end
    step(1);
    n_cmp++;
    if (clr_long !== 1'b0) begin n_err++; $display("FAIL long_one_cycle: clr_long got %b want 0", clr_long); end
    step(12);
    btn_clr_n = 1'b1;
    step(15);
    n_cmp++;
    if (pulse_cnt - p0 !== 1 || long_cnt - l0 !== 1 || tog_cnt - t0 !== 2) begin
      n_err++; $display("FAIL long_totals: pulses %0d longs %0d toggles %0d want 1 1 2", pulse_cnt - p0, long_cnt - l0, tog_cnt - t0);
    end
  endtask

  task automatic test_same_cycle();
    int p0, t0;
    do_reset();
    btn_run_n = 1'b0;
    btn_clr_n = 1'b0;
    step(7);
    n_cmp++;
    if ({clr_pulse, run_en, run_db, clr_db} !== 4'b1011) begin
      n_err++; $display("FAIL same_cycle: clr_pulse/run_en/run_db/clr_db got %b want 1011", {clr_pulse, run_en, run_db, clr_db});
    end
    step(1);
    n_cmp++;
    if (clr_pulse !== 1'b0 || run_en !== 1'b0) begin
      n_err++; $display("FAIL same_cycle_after: clr_pulse/run_en got %b%b want 00", clr_pulse, run_en);
    end
    step(2);
    btn_run_n = 1'b1;
    btn_clr_n = 1'b1;
    step(15);
    p0 = pulse_cnt;
    t0 = tog_cnt;
    btn_run_n = 1'b0;
    step(4);
    rst = 1'b0;
    step(1);
    n_cmp++;
    if ({run_en, clr_pulse, clr_long, run_db, clr_db} !== 5'b0) begin
      n_err++; $display("FAIL mid_reset_outputs: got %b want 00000", {run_en, clr_pulse, clr_long, run_db, clr_db});
    end
    btn_run_n = 1'b1;
    step(2);
    rst = 1'b1;
    step(15);
    n_cmp++;
    if (tog_cnt - t0 !== 0 || pulse_cnt - p0 !== 0 || run_en !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_no_pulse: toggles %0d pulses %0d run_en %b want 0 0 0", tog_cnt - t0, pulse_cnt - p0, run_en);
    end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_bounce();
    test_clr();
    test_long();
    test_same_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
